// File: rtl/uart_frame_dispatcher.sv
// uart_frame_dispatcher: UART byte-stream command front end.
// RX: <code> <PB payload bytes> <code> frames, dispatched as id + payload over
// a valid/ready handshake. TX: serialises a TX_BYTES response, MSB byte first.
// Build option: define UART_FRAME_TIMEOUT_EN to enable the inter-byte timeout
// (otherwise err_timeout is tied to 0 and a partial frame waits indefinitely).
module uart_frame_dispatcher #(
  parameter int         FRAME_BYTES    = 18,
  parameter int         NUM_CMDS       = 8,
  parameter logic [7:0] CMD_BASE       = 8'h40,
  parameter int         TX_BYTES       = 18,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  localparam int        PB             = FRAME_BYTES - 2,
  localparam int        IW             = $clog2(NUM_CMDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  cmd_valid,
  output logic [IW-1:0]         cmd_id,
  output logic [8*PB-1:0]       cmd_payload,
  input  logic                  cmd_ready,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [8*TX_BYTES-1:0] rsp_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [7:0]            err_frame,
  output logic [7:0]            err_unknown,
  output logic [7:0]            err_overrun,
  output logic [7:0]            err_timeout
);

  localparam int CW = $clog2(PB + 1);
  localparam int XW = $clog2(TX_BYTES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_PAYLOAD, RX_END} rx_state_e;
  typedef enum logic       {TX_IDLE, TX_SEND} tx_state_e;

  rx_state_e             rx_state_q;
  logic [7:0]            code_q;
  logic [8*PB-1:0]       shift_q;
  logic [CW-1:0]         cnt_q;
  logic                  cmd_valid_q;
  logic [IW-1:0]         cmd_id_q;
  logic [8*PB-1:0]       cmd_payload_q;
  logic [7:0]            err_frame_q, err_unknown_q, err_overrun_q;
  logic                  in_range;
  logic                  accept;
  logic                  to_fire;

  tx_state_e             tx_state_q;
  logic [8*TX_BYTES-1:0] tx_buf_q;
  logic [XW-1:0]         tx_idx_q;
  logic                  tx_valid_q;
  logic                  rsp_ready_q;

  assign in_range = (int'(rx_data) >= int'(CMD_BASE)) &&
                    (int'(rx_data) <  int'(CMD_BASE) + NUM_CMDS);
  assign accept   = cmd_valid_q & cmd_ready;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    err_timeout_q;

  // A byte in the expiry cycle wins: rx_valid masks the fire condition.
  assign to_fire = (rx_state_q != RX_IDLE) && !rx_valid &&
                   (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter and saturating timeout error count
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q      <= '0;
      err_timeout_q <= '0;
    end else begin
      if (rx_valid || rx_state_q == RX_IDLE || to_fire) to_cnt_q <= '0;
      else                                              to_cnt_q <= to_cnt_q + 1'b1;
      if (to_fire && err_timeout_q != '1) err_timeout_q <= err_timeout_q + 8'd1;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign to_fire     = 1'b0;
  assign err_timeout = '0;
`endif

  // RX frame FSM, command holding register and RX error counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q    <= RX_IDLE;
      code_q        <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_id_q      <= '0;
      cmd_payload_q <= '0;
      err_frame_q   <= '0;
      err_unknown_q <= '0;
      err_overrun_q <= '0;
    end else begin
      if (accept) cmd_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_valid) begin
            if (in_range) begin
              code_q     <= rx_data;
              cnt_q      <= '0;
              rx_state_q <= RX_PAYLOAD;
            end else if (err_unknown_q != '1) begin
              err_unknown_q <= err_unknown_q + 8'd1;
            end
          end
        end
        RX_PAYLOAD: begin
          if (rx_valid) begin
            shift_q <= (shift_q << 8) | (8*PB)'(rx_data);
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CW'(PB - 1)) rx_state_q <= RX_END;
          end else if (to_fire) begin
            rx_state_q <= RX_IDLE;
          end
        end
        RX_END: begin
          if (rx_valid) begin
            rx_state_q <= RX_IDLE;
            if (rx_data != code_q) begin
              if (err_frame_q != '1) err_frame_q <= err_frame_q + 8'd1;
            end else if (!cmd_valid_q || cmd_ready) begin
              // overrides the accept-clear above when load and accept coincide
              cmd_valid_q   <= 1'b1;
              cmd_id_q      <= IW'(code_q - CMD_BASE);
              cmd_payload_q <= shift_q;
            end else if (err_overrun_q != '1) begin
              err_overrun_q <= err_overrun_q + 8'd1;
            end
          end else if (to_fire) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // TX serialiser: latch response, shift bytes out MSB first
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      tx_buf_q    <= '0;
      tx_idx_q    <= '0;
      tx_valid_q  <= 1'b0;
      rsp_ready_q <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (rsp_valid) begin
            tx_buf_q    <= rsp_data;
            tx_idx_q    <= '0;
            tx_valid_q  <= 1'b1;
            rsp_ready_q <= 1'b0;
            tx_state_q  <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            if (tx_idx_q == XW'(TX_BYTES - 1)) begin
              tx_valid_q  <= 1'b0;
              rsp_ready_q <= 1'b1;
              tx_state_q  <= TX_IDLE;
            end else begin
              tx_buf_q <= tx_buf_q << 8;
              tx_idx_q <= tx_idx_q + 1'b1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_id      = cmd_id_q;
  assign cmd_payload = cmd_payload_q;
  assign busy        = (rx_state_q != RX_IDLE);
  assign err_frame   = err_frame_q;
  assign err_unknown = err_unknown_q;
  assign err_overrun = err_overrun_q;
  assign rsp_ready   = rsp_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_buf_q[8*TX_BYTES-1 -: 8];

endmodule
